// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, parameter
// limits and the claim-id width helper.
package irq_ctrl_pkg;

  localparam int MAX_SRC        = 32;
  localparam int MAX_PRIO_WIDTH = 4;

  localparam logic [11:0] OFF_PENDING   = 12'h000;
  localparam logic [11:0] OFF_ENABLE    = 12'h004;
  localparam logic [11:0] OFF_MODE      = 12'h008;
  localparam logic [11:0] OFF_THRESHOLD = 12'h00C;
  localparam logic [11:0] OFF_CLAIM     = 12'h010;
  localparam logic [11:0] OFF_COMPLETE  = 12'h014;
  localparam logic [3:0]  PRIO_PAGE     = 4'h1;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_prio_arb.sv
// Combinational selector: highest priority among eligible sources, lowest
// index wins a tie.
module irq_prio_arb
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC    = 32,
  parameter int PRIO_WIDTH = 3,
  parameter int IDW        = id_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]            elig_i,
  input  logic [NUM_SRC*PRIO_WIDTH-1:0] prio_i,
  output logic                          vld_o,
  output logic [IDW-1:0]                id_o
);

  logic [PRIO_WIDTH-1:0] best;

  // Strict compare while scanning upward keeps the lowest index on ties.
  always_comb begin
    vld_o = 1'b0;
    id_o  = '0;
    best  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (elig_i[i] && (!vld_o || (prio_i[i*PRIO_WIDTH +: PRIO_WIDTH] > best))) begin
        vld_o = 1'b1;
        id_o  = IDW'(i);
        best  = prio_i[i*PRIO_WIDTH +: PRIO_WIDTH];
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller with edge/level sources, priorities, threshold and
// claim/complete, behind a one-cycle-latency native memory port.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC    = 32,
  parameter int PRIO_WIDTH = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               mem_valid_i,
  input  logic [11:0]        mem_addr_i,
  input  logic [31:0]        mem_wdata_i,
  input  logic [3:0]         mem_wstrb_i,
  output logic               mem_ready_o,
  output logic [31:0]        mem_rdata_o,
  output logic               irq_o
);

  localparam int IDW = id_width(NUM_SRC);

  if (NUM_SRC < 1 || NUM_SRC > MAX_SRC || PRIO_WIDTH < 1 || PRIO_WIDTH > MAX_PRIO_WIDTH) begin : g_bad_param
    $error("irq_ctrl: NUM_SRC or PRIO_WIDTH out of range");
  end

  logic [NUM_SRC-1:0] pending_q, pending_d, enable_q, enable_d, mode_q, mode_d;
  logic [NUM_SRC-1:0] inservice_q, inservice_d, src_q;
  logic [NUM_SRC-1:0] edge_det, elig, w1c_clr, claim_oh, cmp_oh;
  logic [PRIO_WIDTH-1:0] thresh_q, thresh_d;
  logic [PRIO_WIDTH-1:0] prio_q [NUM_SRC];
  logic [PRIO_WIDTH-1:0] prio_d [NUM_SRC];
  logic [NUM_SRC*PRIO_WIDTH-1:0] prio_flat;
  logic        armed_q, ready_q, irq_q;
  logic [31:0] rdata_q, rdata_d, bmask, wdat_m;
  logic        req, wr, rd;
  logic        sel_pend, sel_en, sel_mode, sel_thr, sel_claim, sel_cmp, sel_prio;
  logic [5:0]  prio_idx;
  logic        arb_vld;
  logic [IDW-1:0] arb_id;

  assign req    = mem_valid_i & ~ready_q;
  assign wr     = req & (|mem_wstrb_i);
  assign rd     = req & ~(|mem_wstrb_i);
  assign bmask  = {{8{mem_wstrb_i[3]}}, {8{mem_wstrb_i[2]}}, {8{mem_wstrb_i[1]}}, {8{mem_wstrb_i[0]}}};
  assign wdat_m = mem_wdata_i & bmask;

  assign sel_pend  = (mem_addr_i == OFF_PENDING);
  assign sel_en    = (mem_addr_i == OFF_ENABLE);
  assign sel_mode  = (mem_addr_i == OFF_MODE);
  assign sel_thr   = (mem_addr_i == OFF_THRESHOLD);
  assign sel_claim = (mem_addr_i == OFF_CLAIM);
  assign sel_cmp   = (mem_addr_i == OFF_COMPLETE);
  assign sel_prio  = (mem_addr_i[11:8] == PRIO_PAGE) && (mem_addr_i[1:0] == 2'b00);
  assign prio_idx  = mem_addr_i[7:2];

  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    thresh_d = thresh_q;
    prio_d   = prio_q;
    w1c_clr  = '0;
    if (wr && sel_en)   enable_d = (enable_q & ~bmask[NUM_SRC-1:0]) | wdat_m[NUM_SRC-1:0];
    if (wr && sel_mode) mode_d   = (mode_q & ~bmask[NUM_SRC-1:0]) | wdat_m[NUM_SRC-1:0];
    if (wr && sel_thr && mem_wstrb_i[0]) thresh_d = mem_wdata_i[PRIO_WIDTH-1:0];
    if (wr && sel_pend) w1c_clr = wdat_m[NUM_SRC-1:0];
    for (int i = 0; i < NUM_SRC; i++) begin
      if (wr && sel_prio && (prio_idx == 6'(i)) && mem_wstrb_i[0])
        prio_d[i] = mem_wdata_i[PRIO_WIDTH-1:0];
    end
  end

  always_comb begin
    elig      = '0;
    prio_flat = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = pending_q[i] & enable_q[i] & ~inservice_q[i] & (prio_q[i] > thresh_q);
      prio_flat[i*PRIO_WIDTH +: PRIO_WIDTH] = prio_q[i];
    end
  end

  irq_prio_arb #(
    .NUM_SRC    (NUM_SRC),
    .PRIO_WIDTH (PRIO_WIDTH),
    .IDW        (IDW)
  ) u_arb (
    .elig_i (elig),
    .prio_i (prio_flat),
    .vld_o  (arb_vld),
    .id_o   (arb_id)
  );

  always_comb begin
    claim_oh = '0;
    cmp_oh   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_oh[i] = rd && sel_claim && arb_vld && (arb_id == IDW'(i));
      cmp_oh[i]   = wr && sel_cmp && (wdat_m == 32'(i + 1));
    end
  end

  // armed_q masks the first post-reset cycle so a source held high through
  // reset does not look like a rising edge; an edge set wins over any clear.
  assign edge_det    = irq_src_i & ~src_q & mode_q & {NUM_SRC{armed_q}};
  assign pending_d   = (mode_q & ((pending_q & ~w1c_clr & ~claim_oh) | edge_det)) |
                       (~mode_q & irq_src_i);
  assign inservice_d = (inservice_q | claim_oh) & ~cmp_oh;

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      if (sel_pend)       rdata_d = 32'(pending_q);
      else if (sel_en)    rdata_d = 32'(enable_q);
      else if (sel_mode)  rdata_d = 32'(mode_q);
      else if (sel_thr)   rdata_d = 32'(thresh_q);
      else if (sel_claim) rdata_d = arb_vld ? (32'(arb_id) + 32'd1) : 32'd0;
      else if (sel_prio) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (prio_idx == 6'(i)) rdata_d = 32'(prio_q[i]);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q   <= '0;
      enable_q    <= '0;
      mode_q      <= '0;
      inservice_q <= '0;
      src_q       <= '0;
      thresh_q    <= '0;
      armed_q     <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
    end else begin
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      inservice_q <= inservice_d;
      src_q       <= irq_src_i;
      thresh_q    <= thresh_d;
      armed_q     <= 1'b1;
      ready_q     <= req;
      rdata_q     <= rdata_d;
      irq_q       <= |elig;
      prio_q      <= prio_d;
    end
  end

  // Gating with rst_i kills a response already registered when reset lands.
  assign mem_ready_o = ready_q & ~rst_i;
  assign mem_rdata_o = rst_i ? 32'd0 : rdata_q;
  assign irq_o       = irq_q & ~rst_i;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register-access vector table plus hand-written
// interrupt sequences.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int NS = 8;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] irq_src = '0;
  logic          mem_valid = 1'b0;
  logic [11:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_wstrb = '0;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic          irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[22];

  irq_ctrl #(.NUM_SRC(NS), .PRIO_WIDTH(PW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .irq_src_i   (irq_src),
    .mem_valid_i (mem_valid),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_wstrb_i (mem_wstrb),
    .mem_ready_o (mem_ready),
    .mem_rdata_o (mem_rdata),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm, output logic [31:0] r);
    bit got = 0;
    r = '0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      if (mem_ready) begin got = 1; r = mem_rdata; end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: no ready within 4 cycles, expected a ready pulse", nm);
    end
  endtask

  task automatic bus(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    @(posedge clk);
    #1 mem_valid = 1'b0; mem_wstrb = '0;
    wait_ready($sformatf("ready@%03h", a), r);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(a, d, 4'hF, r);
  endtask

  task automatic rdchk(input string nm, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(a, 32'h0, 4'h0, r);
    chk(nm, r, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_valid = 1'b0; mem_wstrb = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    bit seen;

    tbl[0]  = '{12'h000, 32'h0,        4'h0, 32'h0};
    tbl[1]  = '{12'h004, 32'h0,        4'h0, 32'h0};
    tbl[2]  = '{12'h00C, 32'h0,        4'h0, 32'h0};
    tbl[3]  = '{12'h010, 32'h0,        4'h0, 32'h0};
    tbl[4]  = '{12'h004, 32'hFFFF_FFA5, 4'hF, 32'h0};
    tbl[5]  = '{12'h004, 32'h0,        4'h0, 32'hA5};
    tbl[6]  = '{12'h004, 32'h0,        4'h2, 32'h0};
    tbl[7]  = '{12'h004, 32'h0,        4'h0, 32'hA5};
    tbl[8]  = '{12'h008, 32'h3C,       4'h1, 32'h0};
    tbl[9]  = '{12'h008, 32'h0,        4'h0, 32'h3C};
    tbl[10] = '{12'h00C, 32'hFF,       4'hF, 32'h0};
    tbl[11] = '{12'h00C, 32'h0,        4'h0, 32'h7};
    tbl[12] = '{12'h108, 32'h5,        4'hF, 32'h0};
    tbl[13] = '{12'h108, 32'h0,        4'h0, 32'h5};
    tbl[14] = '{12'h120, 32'h7,        4'hF, 32'h0};
    tbl[15] = '{12'h120, 32'h0,        4'h0, 32'h0};
    tbl[16] = '{12'h018, 32'h0,        4'h0, 32'h0};
    tbl[17] = '{12'h00C, 32'h0,        4'h2, 32'h0};
    tbl[18] = '{12'h00C, 32'h0,        4'h0, 32'h7};
    tbl[19] = '{12'h014, 32'h0,        4'h0, 32'h0};
    tbl[20] = '{12'h004, 32'h0,        4'h1, 32'h0};
    tbl[21] = '{12'h004, 32'h0,        4'h0, 32'h0};

    // Reset values and first cycle after reset
    repeat (3) @(negedge clk);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_ready", {31'b0, mem_ready}, 32'h0);
    rst = 1'b0;
    chk("post_rst_irq", {31'b0, irq}, 32'h0);
    chk("post_rst_rdata", mem_rdata, 32'h0);

    // Register access table
    for (int i = 0; i < 22; i++) begin
      bus(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, r);
      if (tbl[i].wstrb == 4'h0) chk($sformatf("vec%0d_%03h", i, tbl[i].addr), r, tbl[i].exp);
    end

    // Edge source 3: irq one cycle after pending, claim 4, pending clears, irq drops
    do_reset();
    wr(OFF_MODE, 32'h8); wr(OFF_ENABLE, 32'h8); wr(12'h10C, 32'h2); wr(OFF_THRESHOLD, 32'h0);
    @(negedge clk); irq_src[3] = 1'b1;
    @(negedge clk); chk("e3_irq_lag", {31'b0, irq}, 32'h0);
    @(negedge clk); chk("e3_irq_hi", {31'b0, irq}, 32'h1);
    rdchk("e3_pending", OFF_PENDING, 32'h8);
    rdchk("e3_claim", OFF_CLAIM, 32'h4);
    rdchk("e3_pend_clr", OFF_PENDING, 32'h0);
    chk("e3_irq_drop", {31'b0, irq}, 32'h0);
    wr(OFF_COMPLETE, 32'h4); idle(2);
    chk("e3_irq_after_cmp", {31'b0, irq}, 32'h0);

    // Tie goes to lowest index, then higher priority wins; ignored complete ids
    do_reset();
    irq_src = 8'h22;
    wr(OFF_ENABLE, 32'hFF); wr(12'h104, 32'h3); wr(12'h114, 32'h3); idle(2);
    rdchk("tie_claim", OFF_CLAIM, 32'h2);
    wr(OFF_COMPLETE, 32'h2);
    wr(12'h114, 32'h4);
    rdchk("prio_claim", OFF_CLAIM, 32'h6);
    rdchk("second_claim", OFF_CLAIM, 32'h2);
    rdchk("none_claim", OFF_CLAIM, 32'h0);
    wr(OFF_COMPLETE, 32'h9); wr(OFF_COMPLETE, 32'h0);
    rdchk("bad_cmp_claim", OFF_CLAIM, 32'h0);
    wr(OFF_COMPLETE, 32'h6);
    rdchk("good_cmp_claim", OFF_CLAIM, 32'h6);
    irq_src = '0;

    // Threshold gating
    do_reset();
    irq_src[0] = 1'b1;
    wr(OFF_ENABLE, 32'h1); wr(12'h100, 32'h3); wr(OFF_THRESHOLD, 32'h3); idle(3);
    chk("thr_irq_lo", {31'b0, irq}, 32'h0);
    rdchk("thr_claim0", OFF_CLAIM, 32'h0);
    wr(OFF_THRESHOLD, 32'h2); idle(2);
    chk("thr_irq_hi", {31'b0, irq}, 32'h1);
    irq_src = '0;

    // Level source 7: held off by in-service until complete
    do_reset();
    irq_src[7] = 1'b1;
    wr(OFF_ENABLE, 32'h80); wr(12'h11C, 32'h1); idle(3);
    chk("lvl_irq_hi", {31'b0, irq}, 32'h1);
    rdchk("lvl_claim", OFF_CLAIM, 32'h8);
    idle(3);
    chk("lvl_irq_held", {31'b0, irq}, 32'h0);
    rdchk("lvl_pending", OFF_PENDING, 32'h80);
    wr(OFF_PENDING, 32'h80);
    rdchk("lvl_w1c_noeff", OFF_PENDING, 32'h80);
    wr(OFF_COMPLETE, 32'h8); idle(2);
    chk("lvl_irq_reassert", {31'b0, irq}, 32'h1);
    irq_src = '0;

    // Edge on source 2 coinciding with W1C of bit 2
    do_reset();
    wr(OFF_MODE, 32'h4);
    @(negedge clk); irq_src[2] = 1'b1;
    @(negedge clk); irq_src[2] = 1'b0;
    rdchk("w1c_pre", OFF_PENDING, 32'h4);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = OFF_PENDING; mem_wdata = 32'h4; mem_wstrb = 4'hF;
    irq_src[2] = 1'b1;
    @(posedge clk);
    #1 mem_valid = 1'b0; mem_wstrb = '0;
    wait_ready("w1c_edge_ready", r);
    rdchk("w1c_edge_set_wins", OFF_PENDING, 32'h4);
    wr(OFF_PENDING, 32'h4);
    rdchk("w1c_clears", OFF_PENDING, 32'h0);
    irq_src = '0;

    // Unmapped read latency, then reset during an in-flight access
    do_reset();
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 12'h018; mem_wstrb = 4'h0;
    @(posedge clk);
    #1 mem_valid = 1'b0;
    @(negedge clk);
    chk("unmap_ready1", {31'b0, mem_ready}, 32'h1);
    chk("unmap_rdata", mem_rdata, 32'h0);
    @(negedge clk);
    chk("unmap_ready_once", {31'b0, mem_ready}, 32'h0);
    wr(OFF_ENABLE, 32'hFF); wr(OFF_MODE, 32'hFF); wr(OFF_THRESHOLD, 32'h1); wr(12'h104, 32'h5);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = OFF_ENABLE; mem_wstrb = 4'h0;
    @(posedge clk);
    #1 mem_valid = 1'b0; rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_ready) seen = 1;
    end
    chk("abort_no_ready", {31'b0, seen}, 32'h0);
    rst = 1'b0;
    chk("abort_ready_after", {31'b0, mem_ready}, 32'h0);
    rdchk("abort_enable", OFF_ENABLE, 32'h0);
    rdchk("abort_mode", OFF_MODE, 32'h0);
    rdchk("abort_thr", OFF_THRESHOLD, 32'h0);
    rdchk("abort_prio1", 12'h104, 32'h0);
    rdchk("abort_pending", OFF_PENDING, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
